run_logger: RTL

Downstream companion to the S/X-driven run controller (the ASM block with states T0/T1/T2, a 4-bit counter and done output G). It watches the controller's start request S and its registered completion pulse G and times each run in clock cycles. It stamps each run with a sequence number and queues the records in a small FIFO. A consumer drains the FIFO over a valid/ready handshake. Sticky flags report dropped records and protocol anomalies.

---
 rtl/run_logger_if.sv | 21 ++
 rtl/run_logger.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/run_logger_if.sv
// Record stream between run_logger and its consumer.
// The logger drives valid/data and the consumer drives ready.
interface run_logger_if #(
  parameter int DW = 12
);
  logic          rec_valid;
  logic          rec_ready;
  logic [DW-1:0] rec_data;

  modport master (
    output rec_valid,
    output rec_data,
    input  rec_ready
  );

  modport slave (
    input  rec_valid,
    input  rec_data,
    output rec_ready
  );
endinterface

// File: rtl/run_logger.sv
// run_logger: times each S->G run of the run controller in clock cycles.
// Each finished run becomes one record {run_id, cycles}. Records are queued
// in a small show-ahead FIFO that a consumer drains over valid/ready.
// Sticky flags report records dropped on a full FIFO (overflow) and a done
// pulse that arrived with no run in progress (stray).
module run_logger #(
  parameter int DEPTH = 4,
  parameter int CW    = 8,
  parameter int IDW   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          S,
  input  logic          G,
  run_logger_if.master  rec,
  output logic          busy,
  output logic          overflow,
  output logic          stray
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = IDW + CW;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] TIMING = 1'b1;

  localparam logic [AW-1:0]  PTR_ONE  = AW'(1'b1);
  localparam logic [AW:0]    CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1'b1);
  localparam logic [AW:0]    CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0]  CW_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0]  CW_ONE   = CW'(1'b1);
  localparam logic [CW-1:0]  CW_MAX   = {CW{1'b1}};
  localparam logic [IDW-1:0] ID_ZERO  = {IDW{1'b0}};
  localparam logic [IDW-1:0] ID_ONE   = IDW'(1'b1);
  localparam logic [DW-1:0]  REC_ZERO = {DW{1'b0}};

  // Registered state
  logic [0:0]     state_r;
  logic [CW-1:0]  timer_r;
  logic [IDW-1:0] next_id_r;
  logic [DW-1:0]  mem_r [DEPTH];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [AW:0]    count_r;
  logic           rec_valid_r;
  logic [DW-1:0]  rec_data_r;
  logic           overflow_r;
  logic           stray_r;

  // Next-state and handshake signals
  logic [0:0]     state_next_s;
  logic [CW-1:0]  timer_next_s;
  logic           push_req_s;
  logic           pop_s;
  logic           full_s;
  logic           push_ok_s;
  logic           push_drop_s;
  logic           stray_hit_s;
  logic [DW-1:0]  record_s;
  logic [AW:0]    count_next_s;
  logic [AW-1:0]  rd_ptr_next_s;
  logic [DW-1:0]  head_next_s;

  // Run FSM next state and cycle timer; S during TIMING is deliberately ignored
  always_comb begin
    state_next_s = state_r;
    timer_next_s = timer_r;
    case (state_r)
      IDLE: begin
        if (S) begin
          state_next_s = TIMING;
          timer_next_s = CW_ONE;
        end else begin
          state_next_s = IDLE;
          timer_next_s = timer_r;
        end
      end
      TIMING: begin
        if (G) begin
          state_next_s = IDLE;
          timer_next_s = CW_ZERO;
        end else if (timer_r != CW_MAX) begin
          state_next_s = TIMING;
          timer_next_s = timer_r + CW_ONE;
        end else begin
          state_next_s = TIMING;
          timer_next_s = timer_r;
        end
      end
      default: begin
        state_next_s = IDLE;
        timer_next_s = CW_ZERO;
      end
    endcase
  end

  // Push/pop decisions: a full FIFO still accepts a push when the head leaves on the same edge
  always_comb begin
    push_req_s  = (state_r == TIMING) && G;
    stray_hit_s = (state_r == IDLE) && G;
    pop_s       = rec_valid_r && rec.rec_ready;
    full_s      = (count_r == CNT_FULL);
    push_ok_s   = push_req_s && (!full_s || pop_s);
    push_drop_s = push_req_s && !push_ok_s;
    record_s    = {next_id_r, timer_r};
  end

  // Occupancy and the head entry the output register must show after this edge
  always_comb begin
    case ({push_ok_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase

    if (pop_s) begin
      rd_ptr_next_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end

    // The new head comes from storage unless the only candidate is the record
    // being written on this very edge (FIFO empty, or one entry that leaves).
    if (pop_s) begin
      if (count_r > CNT_ONE) begin
        head_next_s = mem_r[rd_ptr_next_s];
      end else begin
        head_next_s = record_s;
      end
    end else if (count_r == CNT_ZERO) begin
      head_next_s = record_s;
    end else begin
      head_next_s = rec_data_r;
    end
  end

  // FSM state and timer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      timer_r <= CW_ZERO;
    end else begin
      state_r <= state_next_s;
      timer_r <= timer_next_s;
    end
  end

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= REC_ZERO;
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= record_s;
    end
  end

  // FIFO pointers, occupancy and the registered show-ahead head
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= CNT_ZERO;
      rec_valid_r <= 1'b0;
      rec_data_r  <= REC_ZERO;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      rd_ptr_r    <= rd_ptr_next_s;
      count_r     <= count_next_s;
      rec_valid_r <= (count_next_s != CNT_ZERO);
      rec_data_r  <= head_next_s;
    end
  end

  // Run id advances only on an accepted record; sticky anomaly flags
  always_ff @(posedge clk) begin
    if (reset) begin
      next_id_r  <= ID_ZERO;
      overflow_r <= 1'b0;
      stray_r    <= 1'b0;
    end else begin
      if (push_ok_s) begin
        next_id_r <= next_id_r + ID_ONE;
      end
      if (push_drop_s) begin
        overflow_r <= 1'b1;
      end
      if (stray_hit_s) begin
        stray_r <= 1'b1;
      end
    end
  end

  assign rec.rec_valid = rec_valid_r;
  assign rec.rec_data  = rec_data_r;
  assign busy          = (state_r == TIMING);
  assign overflow      = overflow_r;
  assign stray         = stray_r;

endmodule
